// File: rtl/conv4_ctrl.sv
// conv4_ctrl: sequencer for the stride-2 3x3 conv engine; filter load, IFM streaming, tagged output handshake.
module conv4_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int PE_LAT = 3,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          flt_load,
  output logic [1:0]    flt_idx,
  output logic          ifm_rd_en,
  output logic [AW-1:0] ifm_row_base,
  output logic [AW-1:0] ifm_col,
  output logic          core_en,
  output logic          core_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_row,
  output logic [AW-1:0] out_col
);
  typedef enum logic [2:0] {IDLE, LOAD_F, CLR, STREAM, DRAIN, NEXT, FIN} state_t;
  localparam logic [AW-1:0] LAST_COL  = AW'(IMG_W - 1);
  localparam logic [AW-1:0] LAST_PASS = AW'(IMG_H / 4 - 1);
  state_t state_q, state_d;
  logic [1:0] fidx_q, fidx_d;
  logic [AW-1:0] col_q, col_d, pass_q, pass_d, rb_q, rb_d, ccol_q, ccol_d;
  logic cen_q, cen_d, stall;
  logic [PE_LAT-1:0] vld_q, vld_d;
  logic [PE_LAT-1:0][AW-1:0] oc_q, oc_d;
  always_comb begin
    state_d   = state_q;
    fidx_d    = fidx_q;
    col_d     = col_q;
    pass_d    = pass_q;
    rb_d      = rb_q;
    done      = 1'b0;
    flt_load  = 1'b0;
    core_clr  = 1'b0;
    stall     = vld_q[PE_LAT-1] & ~out_ready;
    ifm_rd_en = (state_q == STREAM) & ~stall;
    core_en   = cen_q & ~stall;
    cen_d     = stall ? cen_q : ifm_rd_en;
    ccol_d    = ifm_rd_en ? col_q : ccol_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_F;
        fidx_d  = '0;
        col_d   = '0;
        pass_d  = '0;
      end
      LOAD_F: begin
        flt_load = 1'b1;
        fidx_d   = (fidx_q == 2'd2) ? 2'd0 : fidx_q + 2'd1;
        state_d  = (fidx_q == 2'd2) ? CLR : LOAD_F;
      end
      CLR: begin
        core_clr = 1'b1;
        rb_d     = pass_q << 2;
        state_d  = STREAM;
      end
      STREAM: if (!stall) begin
        col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        state_d = (col_q == LAST_COL) ? DRAIN : STREAM;
      end
      // Leave only once the last engine column has fully retired and been accepted.
      DRAIN: state_d = (!cen_q && !(|vld_q)) ? NEXT : DRAIN;
      NEXT: begin
        pass_d  = (pass_q < LAST_PASS) ? pass_q + 1'b1 : pass_q;
        state_d = (pass_q < LAST_PASS) ? CLR : FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Odd input columns complete an output; the tag travels with the engine latency.
  for (genvar s = 0; s < PE_LAT; s++) begin : g_pipe
    if (s == 0) begin : g_head
      assign vld_d[0] = stall ? vld_q[0] : core_en & ccol_q[0];
      assign oc_d[0]  = stall ? oc_q[0] : ccol_q >> 1;
    end else begin : g_tail
      assign vld_d[s] = stall ? vld_q[s] : vld_q[s-1];
      assign oc_d[s]  = stall ? oc_q[s] : oc_q[s-1];
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      col_q   <= '0;
      pass_q  <= '0;
      rb_q    <= '0;
      ccol_q  <= '0;
      cen_q   <= 1'b0;
      vld_q   <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      rb_q    <= rb_d;
      ccol_q  <= ccol_d;
      cen_q   <= cen_d;
      vld_q   <= vld_d;
      oc_q    <= oc_d;
    end
  end
  assign busy         = (state_q != IDLE) && (state_q != FIN);
  assign flt_idx      = fidx_q;
  assign ifm_row_base = rb_q;
  assign ifm_col      = col_q;
  assign out_valid    = vld_q[PE_LAT-1];
  assign out_col      = oc_q[PE_LAT-1];
  assign out_row      = pass_q << 1;
endmodule

// File: tb/tb_conv4_ctrl.sv
// tb_conv4_ctrl: scoreboard bench; stimulus queues expected (row,col) tags, a monitor pops them on each transfer.
module tb_conv4_ctrl;
  localparam int AW = 8;
  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic busy, done, flt_load, ifm_rd_en, core_en, core_clr, out_valid;
  logic [1:0] flt_idx;
  logic [AW-1:0] ifm_row_base, ifm_col, out_row, out_col;
  typedef struct packed {logic [AW-1:0] row; logic [AW-1:0] col;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0, cyc = 0;
  int flt_cnt, clr_cnt, rd_cnt, done_cnt, out_cnt, cen_cnt, t_c1, t_v;
  bit st_prev = 0;
  logic [AW-1:0] p_col, p_row, p_icol;

  conv4_ctrl #(.IMG_W(16), .IMG_H(16), .PE_LAT(3), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .flt_load(flt_load), .flt_idx(flt_idx), .ifm_rd_en(ifm_rd_en),
    .ifm_row_base(ifm_row_base), .ifm_col(ifm_col), .core_en(core_en),
    .core_clr(core_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rstn) st_prev = 0;
    if (flt_load) begin
      check("flt_idx", flt_idx, flt_cnt);
      flt_cnt++;
    end
    if (core_clr) clr_cnt++;
    if (ifm_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (core_en) begin
      cen_cnt++;
      if (cen_cnt == 2) t_c1 = cyc;
    end
    if (out_valid && t_v < 0) t_v = cyc;
    if (out_valid && !busy) check("valid_outside_busy", 1, 0);
    if (st_prev) begin
      check("stall_valid_held", out_valid, 1);
      check("stall_col_held", out_col, p_col);
      check("stall_row_held", out_row, p_row);
      check("stall_ifm_col_frozen", ifm_col, p_icol);
    end
    st_prev = out_valid && !out_ready;
    if (st_prev) begin
      check("stall_core_en", core_en, 0);
      check("stall_rd_en", ifm_rd_en, 0);
    end
    p_col = out_col; p_row = out_row; p_icol = ifm_col;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_row", out_row, e.row);
        check("out_col", out_col, e.col);
      end
      out_cnt++;
    end
  end

  task automatic arm_frame();
    flt_cnt = 0; clr_cnt = 0; rd_cnt = 0; done_cnt = 0; out_cnt = 0;
    cen_cnt = 0; t_c1 = -1; t_v = -1;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 8; c++) exp_q.push_back('{row: AW'(p * 2), col: AW'(c)});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high plus a start pulse while busy; 1: 5-cycle stall at 3rd output; 2: random ready
  task automatic run_frame(input int mode);
    int bp = 0;
    bit bp_used = 0;
    int i;
    arm_frame();
    for (i = 0; i < 3000 && done_cnt == 0; i++) begin
      start = (mode == 0 && i == 40);
      if (mode == 1 && !bp_used && out_cnt == 2 && out_valid) begin
        bp = 5; bp_used = 1;
      end
      out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (bp == 0);
      if (bp > 0) bp--;
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1;
    check("frame_timeout", int'(done_cnt != 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("outputs_per_frame", out_cnt, 32);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
    check("flt_load_cycles", flt_cnt, 3);
    check("clr_cycles", clr_cnt, 4);
    check("rd_en_cycles", rd_cnt, 64);
    if (mode == 1) check("bp_applied", int'(bp_used), 1);
  endtask

  initial begin
    int i;
    #3 rstn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", ifm_rd_en, 0);
    check("rst_flt_load", flt_load, 0);
    check("rst_core_clr", core_clr, 0);
    check("rst_ifm_col", ifm_col, 0);
    check("rst_row_base", ifm_row_base, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    run_frame(0);
    check("latency_col1_to_valid", t_v - t_c1, 3);
    run_frame(1);
    run_frame(2);

    arm_frame();
    for (i = 0; i < 2000 && !(ifm_row_base == 8 && ifm_col == 5 && ifm_rd_en); i++) begin
      @(posedge clk); #1;
    end
    check("reach_pass2", int'(ifm_row_base == 8 && ifm_col == 5), 1);
    #2 rstn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_rd_en", ifm_rd_en, 0);
    check("abort_core_en", core_en, 0);
    check("abort_ifm_col", ifm_col, 0);
    check("abort_row_base", ifm_row_base, 0);
    check("abort_out_row", out_row, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("abort_no_done", done_cnt, 0);
    @(posedge clk); #1;

    run_frame(0);
    check("latency_after_abort", t_v - t_c1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
